// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: pipelined barrel shifter with valid/ready on both sides.
// One register stage per shift-amount bit, MSB bit first. Bubbles collapse:
// a stage refills whenever it or any stage downstream of it has a hole.
// Optional feature macro: BARREL_SHIFT_ROTATE_EN (mode 11 = rotate right;
// without it mode 11 behaves as SRL).
module barrel_shift_pipe #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Fixed-distance shift used by every stage. SRA fills with the current
  // MSB, which is always the original operand MSB since SRA never alters it.
  function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] d,
                                               input logic [1:0]       m,
                                               input int unsigned      sh);
    logic [WIDTH-1:0] r;
    case (m)
      2'b00:   r = d << sh;
      2'b10:   r = $signed(d) >>> sh;
`ifdef BARREL_SHIFT_ROTATE_EN
      2'b11:   r = (d >> sh) | (d << (WIDTH - sh));
`endif
      default: r = d >> sh;
    endcase
    return r;
  endfunction

  logic [SHW-1:0]            w_vld;
  logic [SHW-1:0]            w_ld;
  logic [SHW-1:0][WIDTH-1:0] w_data;

  for (genvar k = 0; k < SHW; k++) begin : g_stg
    localparam int RW = SHW - k;              // shamt bits still to apply
    localparam int SH = 1 << (SHW - 1 - k);   // distance applied here

    logic             w_vin;
    logic [WIDTH-1:0] w_din;
    logic [WIDTH-1:0] w_dsh;
    logic [RW-1:0]    w_rem;
    logic [1:0]       w_mode;
    logic             r_vld;
    logic [WIDTH-1:0] r_data;

    if (k == 0) begin : g_src
      assign w_vin  = in_valid;
      assign w_din  = in_data;
      assign w_rem  = shamt;
      assign w_mode = mode;
    end else begin : g_src
      assign w_vin  = w_vld[k-1];
      assign w_din  = w_data[k-1];
      assign w_rem  = g_stg[k-1].g_fwd.r_rem;
      assign w_mode = g_stg[k-1].g_fwd.r_mode;
    end

    assign w_dsh = w_rem[RW-1] ? f_shift(w_din, w_mode, SH) : w_din;

    // Load when the output drains or any stage from here onward is empty
    assign w_ld[k]   = out_ready | ~(&w_vld[SHW-1:k]);
    assign w_vld[k]  = r_vld;
    assign w_data[k] = r_data;

    // Stage valid/data register; a bubble clears valid but keeps old data
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld  <= 1'b0;
        r_data <= '0;
      end else if (w_ld[k]) begin
        r_vld <= w_vin;
        if (w_vin) r_data <= w_dsh;
      end
    end

    if (k < SHW - 1) begin : g_fwd
      logic [RW-2:0] r_rem;
      logic [1:0]    r_mode;

      // Carry the unconsumed shamt bits and mode to the next stage
      always_ff @(posedge clk) begin
        if (rst) begin
          r_rem  <= '0;
          r_mode <= '0;
        end else if (w_ld[k] && w_vin) begin
          r_rem  <= w_rem[RW-2:0];
          r_mode <= w_mode;
        end
      end
    end
  end

  assign in_ready  = w_ld[0];
  assign out_valid = w_vld[SHW-1];
  assign out_data  = w_data[SHW-1];

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed bench for barrel_shift_pipe (WIDTH=8): vector table per mode,
// streaming, backpressure, bubble collapse and mid-stream reset.
module tb_barrel_shift_pipe;
  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [2:0] shamt;
  logic [1:0] mode;

  always #5 clk = ~clk;

  barrel_shift_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .shamt(shamt), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data));

  int checks = 0, errors = 0;
  int n_in = 0, n_out = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] s,
                                       input logic [1:0] m);
    logic [15:0] t;
    case (m)
      2'b00: t = {8'h00, d << s};
      2'b01: t = {8'h00, d >> s};
      2'b10: t = {{8{d[7]}}, d} >> s;
`ifdef BARREL_SHIFT_ROTATE_EN
      default: t = {d, d} >> s;
`else
      default: t = {8'h00, d >> s};
`endif
    endcase
    return t[7:0];
  endfunction

  // Scoreboard: handshakes are evaluated mid-cycle, ahead of the edge that completes them
  logic [7:0] q[$];
  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected: got output %0h expected none", out_data);
        end else chk("sb_data", out_data, q.pop_front());
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_data, shamt, mode));
        n_in++;
      end
    end
  end

  typedef struct {
    logic [7:0] d;
    logic [2:0] s;
    logic [1:0] m;
    logic [7:0] e;
  } vec_t;
  vec_t vt[10];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rnd_op();
    in_data = 8'($urandom);
    shamt   = 3'($urandom_range(0, 7));
    mode    = 2'($urandom_range(0, 3));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal;
  end

  initial begin
    int   base_in, base_out, acc_cnt;
    logic acc, have_held;
    logic [7:0] held;

    vt[0] = '{8'hB5, 3'd3, 2'b00, 8'hA8};
    vt[1] = '{8'hB5, 3'd3, 2'b01, 8'h16};
    vt[2] = '{8'hB5, 3'd3, 2'b10, 8'hF6};
`ifdef BARREL_SHIFT_ROTATE_EN
    vt[3] = '{8'hB5, 3'd3, 2'b11, 8'hB6};
`else
    vt[3] = '{8'hB5, 3'd3, 2'b11, 8'h16};
`endif
    vt[4] = '{8'h5A, 3'd0, 2'b00, 8'h5A};
    vt[5] = '{8'h5A, 3'd0, 2'b01, 8'h5A};
    vt[6] = '{8'h5A, 3'd0, 2'b10, 8'h5A};
    vt[7] = '{8'h5A, 3'd0, 2'b11, 8'h5A};
    vt[8] = '{8'h80, 3'd7, 2'b10, 8'hFF};
    vt[9] = '{8'h80, 3'd7, 2'b01, 8'h01};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; shamt = '0; mode = '0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_in_ready", in_ready, 1'b1);
    step();

    // Single transactions: result visible after edge t+2
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = vt[i].d; shamt = vt[i].s; mode = vt[i].m;
      @(negedge clk);
      chk("vec_in_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      step();
      @(negedge clk);
      chk("vec_early_valid", out_valid, 1'b0);
      step();
      @(negedge clk);
      chk("vec_valid", out_valid, 1'b1);
      chk("vec_data", out_data, vt[i].e);
      step();
    end

    // Back-to-back stream of 16 at full throughput
    base_out = n_out;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; rnd_op();
      @(negedge clk);
      chk("stream_in_ready", in_ready, 1'b1);
      step();
    end
    in_valid = 1'b0;
    step(); step(); step();
    chk("stream_count", 8'(n_out - base_out), 8'd16);

    // Backpressure: out_ready low for 6 cycles of continuous offer
    base_in = n_in; base_out = n_out; acc_cnt = 0; have_held = 1'b0; held = '0;
    out_ready = 1'b0; in_valid = 1'b1; rnd_op();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) acc_cnt++;
      if (have_held) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, held);
      end else if (out_valid) begin
        have_held = 1'b1; held = out_data;
      end
      step();
      if (acc) rnd_op();
    end
    @(negedge clk);
    chk("bp_accepts", 8'(acc_cnt), 8'd3);
    chk("bp_full_ready", in_ready, 1'b0);
    step();
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("bp_resume_ready", in_ready, 1'b1);
      step();
      rnd_op();
    end
    in_valid = 1'b0;
    repeat (4) step();
    chk("bp_in_count", 8'(n_in - base_in), 8'd11);
    chk("bp_out_count", 8'(n_out - base_out), 8'd11);

    // Bubble collapse: second operand closes up behind a stalled first one
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; shamt = 3'd1; mode = 2'b00;
    step();
    in_valid = 1'b0;
    step(); step();
    in_valid = 1'b1; in_data = 8'h40; shamt = 3'd2; mode = 2'b01;
    @(negedge clk);
    chk("bub_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    step(); step();
    @(negedge clk);
    chk("bub_stall_valid", out_valid, 1'b1);
    chk("bub_stall_data", out_data, 8'h22);
    chk("bub_stall_ready", in_ready, 1'b1);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bub_first_data", out_data, 8'h22);
    step();
    @(negedge clk);
    chk("bub_second_valid", out_valid, 1'b1);
    chk("bub_second_data", out_data, 8'h10);
    step();
    @(negedge clk);
    chk("bub_empty", out_valid, 1'b0);
    step();

    // Reset with three operands in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; rnd_op();
      step();
    end
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_out_data", out_data, 8'h00);
    chk("mrst_in_ready", in_ready, 1'b1);
    step();
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("mrst_no_stale", out_valid, 1'b0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
